// File: rtl/exception_arbiter_if.sv
// ============================================================================
// exception_arbiter_if
// MEM-stage exception arbiter bus: MEM flags, CP0 state/bypass and CP0 outputs.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface exception_arbiter_if;
  logic        instValid_i;
  logic [7:0]  excFlags_i;
  logic [31:0] pc_i;
  logic [31:0] memAddr_i;
  logic        inDelaySlot_i;
  logic [31:0] status_i;
  logic [31:0] cause_i;
  logic [31:0] epc_i;
  logic [31:0] ebase_i;
  logic        cp0WriteEnable_i;
  logic [4:0]  cp0WriteAddr_i;
  logic [31:0] cp0WriteData_i;
  logic [5:0]  int_i;
  logic [5:0]  int_o;
  logic [31:0] exceptionType_o;
  logic [31:0] exceptionAddr_o;
  logic        inDelaySlot_o;
  logic [31:0] badVaddr_o;
  logic        flush_o;
  logic [31:0] newPc_o;

  modport slave (
    input  instValid_i, excFlags_i, pc_i, memAddr_i, inDelaySlot_i,
    input  status_i, cause_i, epc_i, ebase_i,
    input  cp0WriteEnable_i, cp0WriteAddr_i, cp0WriteData_i, int_i,
    output int_o, exceptionType_o, exceptionAddr_o, inDelaySlot_o,
    output badVaddr_o, flush_o, newPc_o
  );

  modport master (
    output instValid_i, excFlags_i, pc_i, memAddr_i, inDelaySlot_i,
    output status_i, cause_i, epc_i, ebase_i,
    output cp0WriteEnable_i, cp0WriteAddr_i, cp0WriteData_i, int_i,
    input  int_o, exceptionType_o, exceptionAddr_o, inDelaySlot_o,
    input  badVaddr_o, flush_o, newPc_o
  );
endinterface

`default_nettype wire

// File: rtl/exception_arbiter.sv
// ============================================================================
// exception_arbiter
// Fixed-priority MEM exception/interrupt select feeding CP0, with flush FSM.
// Optional macro INT_SYNC_EN: 2-flop synchronizer on int_i -> int_o.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module exception_arbiter #(
  parameter logic [31:0] EXC_OFFSET   = 32'h0000_0180,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  exception_arbiter_if.slave bus
);

  localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CNT_W-1:0] c_cnt_init = CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);
  localparam logic [4:0] c_reg_status = 5'd12;
  localparam logic [4:0] c_reg_cause  = 5'd13;
  localparam logic [4:0] c_reg_epc    = 5'd14;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;

  // Same-cycle CP0 write bypass (WB write not yet visible in CP0 outputs).
  logic        w_byp_status;
  logic        w_byp_cause;
  logic        w_byp_epc;
  logic        w_ie;
  logic        w_exl;
  logic [7:0]  w_im;
  logic [7:0]  w_ip;
  logic [31:0] w_epc;
  logic        w_unused;

  assign w_byp_status = bus.cp0WriteEnable_i && (bus.cp0WriteAddr_i == c_reg_status);
  assign w_byp_cause  = bus.cp0WriteEnable_i && (bus.cp0WriteAddr_i == c_reg_cause);
  assign w_byp_epc    = bus.cp0WriteEnable_i && (bus.cp0WriteAddr_i == c_reg_epc);

  assign w_ie  = w_byp_status ? bus.cp0WriteData_i[0]    : bus.status_i[0];
  assign w_exl = w_byp_status ? bus.cp0WriteData_i[1]    : bus.status_i[1];
  assign w_im  = w_byp_status ? bus.cp0WriteData_i[15:8] : bus.status_i[15:8];
  assign w_ip  = {bus.cause_i[15:10],
                  (w_byp_cause ? bus.cp0WriteData_i[9:8] : bus.cause_i[9:8])};
  assign w_epc = w_byp_epc ? bus.cp0WriteData_i : bus.epc_i;

  assign w_unused = ^{bus.status_i[31:16], bus.status_i[7:2],
                      bus.cause_i[31:16], bus.cause_i[7:0]};

  logic        w_irq;
  logic [7:0]  w_flags;
  logic        w_exc_valid;
  logic [31:0] w_exc_type;
  logic [31:0] w_bad_vaddr;
  logic [31:0] w_target;

  assign w_irq   = bus.instValid_i && w_ie && !w_exl && ((w_ip & w_im) != 8'h00);
  assign w_flags = bus.instValid_i ? bus.excFlags_i : 8'h00;

  always_comb begin
    w_exc_valid = 1'b1;
    w_exc_type  = 32'h0;
    w_bad_vaddr = 32'h0;
    w_target    = bus.ebase_i + EXC_OFFSET;
    if (w_irq) begin
      w_exc_type = 32'h1;
    end else if (w_flags[0]) begin
      w_exc_type  = 32'h4;
      w_bad_vaddr = bus.pc_i;
    end else if (w_flags[1]) begin
      w_exc_type = 32'ha;
    end else if (w_flags[2]) begin
      w_exc_type = 32'hc;
    end else if (w_flags[3]) begin
      w_exc_type = 32'h8;
    end else if (w_flags[4]) begin
      w_exc_type = 32'h9;
    end else if (w_flags[5]) begin
      w_exc_type = 32'he;
      w_target   = w_epc;
    end else if (w_flags[6]) begin
      w_exc_type  = 32'h4;
      w_bad_vaddr = bus.memAddr_i;
    end else if (w_flags[7]) begin
      w_exc_type  = 32'h5;
      w_bad_vaddr = bus.memAddr_i;
    end else begin
      w_exc_valid = 1'b0;
    end
  end

  // Exception fields pulse for one cycle; flush/newPc persist FLUSH_CYCLES cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state             <= ST_IDLE;
      r_cnt               <= '0;
      bus.exceptionType_o <= 32'h0;
      bus.exceptionAddr_o <= 32'h0;
      bus.inDelaySlot_o   <= 1'b0;
      bus.badVaddr_o      <= 32'h0;
      bus.flush_o         <= 1'b0;
      bus.newPc_o         <= 32'h0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_exc_valid) begin
            bus.exceptionType_o <= w_exc_type;
            bus.exceptionAddr_o <= bus.pc_i;
            bus.inDelaySlot_o   <= bus.inDelaySlot_i;
            bus.badVaddr_o      <= w_bad_vaddr;
            bus.flush_o         <= 1'b1;
            bus.newPc_o         <= w_target;
            r_cnt               <= c_cnt_init;
            r_state             <= (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_IDLE;
          end else begin
            bus.exceptionType_o <= 32'h0;
            bus.exceptionAddr_o <= 32'h0;
            bus.inDelaySlot_o   <= 1'b0;
            bus.badVaddr_o      <= 32'h0;
            bus.flush_o         <= 1'b0;
            bus.newPc_o         <= 32'h0;
          end
        end
        ST_FLUSH: begin
          bus.exceptionType_o <= 32'h0;
          bus.exceptionAddr_o <= 32'h0;
          bus.inDelaySlot_o   <= 1'b0;
          bus.badVaddr_o      <= 32'h0;
          bus.flush_o         <= 1'b1;
          r_cnt               <= r_cnt - c_cnt_one;
          if (r_cnt <= c_cnt_one) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

`ifdef INT_SYNC_EN
  logic [5:0] r_int_meta;
  logic [5:0] r_int_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_int_meta <= 6'h0;
      r_int_sync <= 6'h0;
    end else begin
      r_int_meta <= bus.int_i;
      r_int_sync <= r_int_meta;
    end
  end

  assign bus.int_o = r_int_sync;
`else
  assign bus.int_o = bus.int_i;
`endif

endmodule

`default_nettype wire

// File: doc/exception_arbiter.md
Name: exception_arbiter

Overview:
- MEM-stage exception arbiter. Sits directly upstream of the CP0 register file.
- Collects per-instruction exception flags from MEM and checks for pending interrupts using CP0 STATUS/CAUSE, with same-cycle write bypass.
- Selects exactly one exception by fixed priority and drives CP0's exception inputs (type, address, delay-slot, bad vaddr), all registered.
- Drives the pipeline flush and redirect PC through a small flush FSM.

Parameters:
- EXC_OFFSET, 32'h00000180, offset added to EBASE for all non-ERET exception vectors.
- FLUSH_CYCLES, 2, number of cycles flush_o stays high per exception (min 1).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- instValid_i  in  1  MEM stage holds a real (non-bubble) instruction
- excFlags_i  in  8  [0] fetch AdEL, [1] RI, [2] Ov, [3] syscall, [4] break, [5] eret, [6] load AdEL, [7] store AdES
- pc_i  in  32  PC of MEM instruction
- memAddr_i  in  32  data address of MEM load/store
- inDelaySlot_i  in  1  MEM instruction is in a branch delay slot
- status_i  in  32  CP0 STATUS
- cause_i  in  32  CP0 CAUSE
- epc_i  in  32  CP0 EPC
- ebase_i  in  32  CP0 EBASE
- cp0WriteEnable_i  in  1  CP0 write in flight (WB)
- cp0WriteAddr_i  in  5  CP0 write register number
- cp0WriteData_i  in  32  CP0 write data
- int_i  in  6  raw hardware interrupt lines
- int_o  out  6  interrupt lines to CP0
- exceptionType_o  out  32  to CP0
- exceptionAddr_o  out  32  faulting PC to CP0
- inDelaySlot_o  out  1  to CP0
- badVaddr_o  out  32  to CP0
- flush_o  out  1  flush IF..MEM
- newPc_o  out  32  redirect target, valid while flush_o=1

Behaviour:
- Bypass: if cp0WriteEnable_i and cp0WriteAddr_i==12, use cp0WriteData_i as STATUS. If addr==14, use it as EPC. If addr==13, use CAUSE with [9:8] taken from the write data.
- Interrupt pending when all of the following hold:
  - STATUS[0]==1 (IE)
  - STATUS[1]==0 (EXL)
  - (CAUSE[15:8] & STATUS[15:8]) != 0
  - instValid_i==1
- Priority, highest first, with resulting type code:
  - interrupt -> 0x1
  - fetch AdEL -> 0x4
  - RI -> 0xa
  - Ov -> 0xc
  - syscall -> 0x8
  - break -> 0x9
  - eret -> 0xe
  - load AdEL -> 0x4
  - store AdES -> 0x5
  - none -> 0x0
- Flags are ignored when instValid_i==0.
- badVaddr: pc_i for fetch AdEL, memAddr_i for load AdEL / store AdES, otherwise 0.
- Target: eret -> bypassed EPC. Any other exception -> ebase_i + EXC_OFFSET, 32-bit wrap.
- FSM has two states, IDLE and FLUSH, plus an internal counter.
  - IDLE with an exception selected: next cycle exceptionType_o/exceptionAddr_o/inDelaySlot_o/badVaddr_o hold the selection for exactly 1 cycle. flush_o=1, newPc_o=target, counter=FLUSH_CYCLES-1, go to FLUSH (or stay IDLE if FLUSH_CYCLES==1).
  - IDLE with no exception: all exception outputs 0, flush_o=0.
  - FLUSH: exception outputs forced to 0. flush_o=1 and newPc_o held. Counter decrements; on 0 return to IDLE. New flags/interrupts ignored in FLUSH (flushed instructions).
- Latency: detection to flush_o/CP0 inputs is 1 cycle.
- Reset (any state, incl. mid-FLUSH), next edge:
  - FSM=IDLE, counter=0.
  - All outputs 0, including int_o and synchronizer flops.

Optional Feature:
- Macro INT_SYNC_EN.
- Defined: int_i passes through a 2-flop synchronizer to int_o (2-cycle latency, reset to 0).
- Undefined: int_o = int_i combinationally.

Test Plan:
- Syscall: instValid_i=1, excFlags_i=0x08, pc_i=0x80001000, ebase_i=0 -> next cycle exceptionType_o=0x8, exceptionAddr_o=0x80001000, flush_o=1, newPc_o=0x180. flush_o stays high 2 cycles, then 0.
- Priority: excFlags_i=0x82 with memAddr_i=0x13 -> type 0xa, badVaddr_o=0. excFlags_i=0x80 alone -> type 0x5, badVaddr_o=0x13.
- Interrupt bypass: status_i=0, cause_i[10]=1, same-cycle write STATUS=0x0000_0401 -> type 0x1, flush_o=1. Same with EXL=1 written -> no exception.
- ERET bypass: epc_i=0x100, simultaneous write EPC=0x200, excFlags_i=0x20 -> type 0xe, newPc_o=0x200.
- Flush masking and reset: exception, then fetch AdEL during FLUSH -> ignored. rst pulsed mid-FLUSH -> flush_o=0 and type 0 next cycle.
- INT_SYNC_EN: int_i=6'b000001 -> int_o rises exactly 2 cycles later. Without the macro -> same cycle.
